// File: rtl/mem_port_arbiter_if.sv
// Memory port arbitration bundle: request/done handshakes in, grant/owner and status out.
interface mem_port_arbiter_if #(
  parameter int CNT_W = 8
) ();

  logic [2:0]       req;
  logic [2:0]       done;
  logic [2:0]       grant;
  logic [1:0]       owner;
  logic [1:0]       arb_state;
  logic [2:0]       preempted;
  logic [CNT_W-1:0] nb_preempt;
  logic [CNT_W-1:0] nb_timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  owner,
    input  arb_state,
    input  preempted,
    input  nb_preempt,
    input  nb_timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output owner,
    output arb_state,
    output preempted,
    output nb_preempt,
    output nb_timeout
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way memory port arbiter: M1 high priority with preemption, M2/M3 round-robin,
// bounded ownership through a hold timer, one dead RELEASE cycle between owners.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no owner, arbitrate sampled req every cycle
// OWN_LP    | M2 or M3 owns the port, may be preempted by M1 or time out
// OWN_HP    | M1 owns the port, never preempted, may time out
// RELEASE   | dead cycle with grant=000; arbitration for the next owner
module mem_port_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int CNT_W      = 8,
  parameter int PREEMPT_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_LP  = 2'd1,
    S_OWN_HP  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rr_m3_q, rr_m3_d;
  logic [2:0]        preempted_q, preempted_d;
  logic [CNT_W-1:0]  nb_pre_q, nb_to_q;
  logic              pre_ev, to_ev;
  logic [2:0]        own_vec;
  logic              own_done, own_req, release_ev;

  function automatic logic [2:0] owner_onehot(input logic [1:0] o);
    logic [2:0] v;
    case (o)
      2'd1:    v = 3'b001;
      2'd2:    v = 3'b010;
      2'd3:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd0;
      hold_q      <= '0;
      rr_m3_q     <= 1'b1;
      preempted_q <= 3'b000;
      nb_pre_q    <= '0;
      nb_to_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      rr_m3_q     <= rr_m3_d;
      preempted_q <= preempted_d;
      if (pre_ev && (nb_pre_q != '1)) nb_pre_q <= nb_pre_q + 1'b1;
      if (to_ev && (nb_to_q != '1))   nb_to_q  <= nb_to_q + 1'b1;
    end
  end

  always_comb begin
    own_vec  = owner_onehot(owner_q);
    own_done = |(bus.done & own_vec);
    own_req  = |(bus.req & own_vec);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    rr_m3_d     = rr_m3_q;
    preempted_d = 3'b000;
    pre_ev      = 1'b0;
    to_ev       = 1'b0;
    release_ev  = 1'b0;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        hold_d = '0;
        if (bus.req[0]) begin
          state_d = S_OWN_HP;
          owner_d = 2'd1;
        end else if (bus.req[1] && bus.req[2]) begin
          // tie goes to whichever LP module did not win the last tie
          state_d = S_OWN_LP;
          owner_d = rr_m3_q ? 2'd2 : 2'd3;
          rr_m3_d = ~rr_m3_q;
        end else if (bus.req[1]) begin
          state_d = S_OWN_LP;
          owner_d = 2'd2;
        end else if (bus.req[2]) begin
          state_d = S_OWN_LP;
          owner_d = 2'd3;
        end else begin
          state_d = S_IDLE;
          owner_d = 2'd0;
        end
      end
      default: begin
        if (own_done || !own_req) begin
          release_ev = 1'b1;
        end else if ((state_q == S_OWN_LP) && (PREEMPT_EN != 0) && bus.req[0]) begin
          release_ev  = 1'b1;
          pre_ev      = 1'b1;
          preempted_d = own_vec;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          release_ev = 1'b1;
          to_ev      = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
        if (release_ev) begin
          state_d = S_RELEASE;
          owner_d = 2'd0;
        end
      end
    endcase
  end

  // all outputs decode from registers only, so no input reaches an output combinationally
  always_comb begin
    bus.grant      = owner_onehot(owner_q);
    bus.owner      = owner_q;
    bus.arb_state  = state_q;
    bus.preempted  = preempted_q;
    bus.nb_preempt = nb_pre_q;
    bus.nb_timeout = nb_to_q;
  end

endmodule
